// File: rtl/memory_access_sequencer.sv
// Load/store sequencer driving memory controller control inputs.
// Issues LOAD / STORE_PRELOAD+STORE sequences, captures data, tracks faults.
module memory_access_sequencer #(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               accessKind,
    input  logic [2:0]               funct3In,
    input  logic [31:0]              rs1In,
    input  logic [31:0]              immediateIIn,
    input  logic [31:0]              immediateSIn,
    input  logic [31:0]              rs2In,
    output logic                     ready,
    output logic                     done,
    output logic [31:0]              loadData,
    output logic                     fault,
    output logic                     illegalRequest,
    output logic [1:0]               memoryMode,
    output logic [2:0]               funct3,
    output logic [31:0]              rs1,
    output logic [31:0]              immediateI,
    output logic [31:0]              immediateS,
    output logic [31:0]              rs2,
    input  logic                     memoryUnalignedAccess,
    input  logic [31:0]              memoryOutput,
    output logic [COUNTER_WIDTH-1:0] loadCount,
    output logic [COUNTER_WIDTH-1:0] storeCount
);

    localparam logic [1:0] MODE_NOP     = 2'd0;
    localparam logic [1:0] MODE_LOAD    = 2'd1;
    localparam logic [1:0] MODE_PRELOAD = 2'd2;
    localparam logic [1:0] MODE_STORE   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LCAP,
        S_PRE,
        S_STORE,
        S_DONE,
        S_HALT
    } state_t;

    state_t                   state_q, state_d;
    logic                     ready_q, done_q;
    logic                     fault_q, illegal_q;
    logic [1:0]               mode_q;
    logic [31:0]              load_data_q;
    logic [2:0]               funct3_q;
    logic [31:0]              rs1_q, imm_i_q, imm_s_q, rs2_q;
    logic [COUNTER_WIDTH-1:0] load_cnt_q, store_cnt_q;

    logic accept;
    logic kind_none, kind_load, kind_store;
    logic ld_ok, st_ok;
    logic probe;

    assign accept     = ready_q && start;
    assign kind_none  = (accessKind == 2'b00);
    assign kind_load  = (accessKind == 2'b01);
    assign kind_store = (accessKind == 2'b10);
    assign probe      = (state_q == S_LOAD) || (state_q == S_PRE);

    always_comb begin
        ld_ok = 1'b0;
        st_ok = 1'b0;
        case (funct3In)
            3'b000, 3'b001, 3'b010: begin
                ld_ok = 1'b1;
                st_ok = 1'b1;
            end
            3'b100, 3'b101: ld_ok = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        kind_none:           state_d = S_DONE;
                        kind_load && ld_ok:  state_d = S_LOAD;
                        kind_store && st_ok: state_d = S_PRE;
                        default:             state_d = S_HALT;
                    endcase
                end
            end
            S_LOAD:  state_d = memoryUnalignedAccess ? S_HALT : S_LCAP;
            S_LCAP:  state_d = S_DONE;
            S_PRE:   state_d = memoryUnalignedAccess ? S_HALT : S_STORE;
            S_STORE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    function automatic logic [1:0] mode_of(state_t s);
        unique case (s)
            S_LOAD:  return MODE_LOAD;
            S_PRE:   return MODE_PRELOAD;
            S_STORE: return MODE_STORE;
            default: return MODE_NOP;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            illegal_q   <= 1'b0;
            mode_q      <= MODE_NOP;
            load_data_q <= '0;
            funct3_q    <= '0;
            rs1_q       <= '0;
            imm_i_q     <= '0;
            imm_s_q     <= '0;
            rs2_q       <= '0;
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == S_IDLE);
            done_q  <= (state_d == S_DONE);
            mode_q  <= mode_of(state_d);
            if (accept) begin
                funct3_q <= funct3In;
                rs1_q    <= rs1In;
                imm_i_q  <= immediateIIn;
                imm_s_q  <= immediateSIn;
                rs2_q    <= rs2In;
            end
            if (probe && memoryUnalignedAccess) begin
                fault_q <= 1'b1;
            end
            if (accept && state_d == S_HALT) begin
                illegal_q <= 1'b1;
            end
            if (state_q == S_LCAP) begin
                load_data_q <= memoryOutput;
                load_cnt_q  <= load_cnt_q + COUNTER_WIDTH'(1);
            end
            if (state_q == S_STORE) begin
                store_cnt_q <= store_cnt_q + COUNTER_WIDTH'(1);
            end
        end
    end

    // Reset gating keeps a write from escaping in the reset cycle
    assign memoryMode     = reset ? MODE_NOP : mode_q;
    assign ready          = ready_q;
    assign done           = done_q;
    assign fault          = fault_q;
    assign illegalRequest = illegal_q;
    assign loadData       = load_data_q;
    assign funct3         = funct3_q;
    assign rs1            = rs1_q;
    assign immediateI     = imm_i_q;
    assign immediateS     = imm_s_q;
    assign rs2            = rs2_q;
    assign loadCount      = load_cnt_q;
    assign storeCount     = store_cnt_q;

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Directed bench for memory_access_sequencer with a tiny controller model.
module tb_memory_access_sequencer;

    localparam logic [1:0] M_NOP   = 2'd0;
    localparam logic [1:0] M_LOAD  = 2'd1;
    localparam logic [1:0] M_PRE   = 2'd2;
    localparam logic [1:0] M_STORE = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  accessKind = '0;
    logic [2:0]  funct3In = '0;
    logic [31:0] rs1In = '0, immIIn = '0, immSIn = '0, rs2In = '0;
    logic        ready, done, fault, illegal;
    logic [31:0] loadData;
    logic [1:0]  memoryMode;
    logic [2:0]  funct3;
    logic [31:0] rs1, immI, immS, rs2;
    logic        ua;
    logic [31:0] memOut;
    logic [1:0]  loadCount, storeCount;

    logic        ua_en = 1'b0;
    logic        was_load = 1'b0;
    logic [31:0] mem_val = '0;

    int checks = 0;
    int errors = 0;

    memory_access_sequencer #(.COUNTER_WIDTH(2)) dut (
        .clock(clk), .reset(reset), .start(start),
        .accessKind(accessKind), .funct3In(funct3In),
        .rs1In(rs1In), .immediateIIn(immIIn),
        .immediateSIn(immSIn), .rs2In(rs2In),
        .ready(ready), .done(done), .loadData(loadData),
        .fault(fault), .illegalRequest(illegal),
        .memoryMode(memoryMode), .funct3(funct3),
        .rs1(rs1), .immediateI(immI),
        .immediateS(immS), .rs2(rs2),
        .memoryUnalignedAccess(ua), .memoryOutput(memOut),
        .loadCount(loadCount), .storeCount(storeCount)
    );

    always #5 clk = ~clk;

    // Controller model: alignment probe in LOAD/PRELOAD, data one cycle after LOAD
    assign ua = ua_en && (memoryMode == M_LOAD || memoryMode == M_PRE);
    always @(posedge clk) was_load <= (memoryMode == M_LOAD);
    assign memOut = was_load ? mem_val : 32'hBAD0_BAD0;

    typedef struct {
        logic [1:0]  kind;
        logic [2:0]  f3;
        logic [31:0] a, ii, is, b, mem;
        int          lat;
        logic [5:0]  modes;
        logic [31:0] ld;
        logic [1:0]  lc, sc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ua_en = 1'b0;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic txn(input logic [1:0] k, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] ii,
                       input logic [31:0] is, input logic [31:0] b,
                       input logic [31:0] m, input logic u,
                       output int lat, output logic [5:0] md,
                       output logic ill1);
        @(negedge clk);
        start = 1'b1;
        accessKind = k;
        funct3In = f;
        rs1In = a;
        immIIn = ii;
        immSIn = is;
        rs2In = b;
        mem_val = m;
        ua_en = u;
        @(negedge clk);
        start = 1'b0;
        accessKind = 2'b11;
        funct3In = 3'b111;
        rs1In = 32'hFFFF_FFFF;
        immIIn = 32'hFFFF_FFFF;
        immSIn = 32'hFFFF_FFFF;
        rs2In = 32'hFFFF_FFFF;
        lat = -1;
        md = '0;
        ill1 = illegal;
        for (int c = 1; c <= 8; c++) begin
            if (c <= 3) md[2*(c-1) +: 2] = memoryMode;
            if (done) begin
                lat = c;
                break;
            end
            if (c < 8) @(negedge clk);
        end
    endtask

    task automatic watch_halt(input string name);
        int bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ready || done || memoryMode != M_NOP) bad++;
        end
        chk({name, "_halt20"}, bad, 0);
    endtask

    int lat, gap, prev, dcount;
    logic [5:0] md;
    logic ill1;

    initial begin
        vecs[0] = '{2'b00, 3'b000, 32'h10, 0, 0, 32'h1, 0,
                    1, 6'b000000, 32'h0, 2'd0, 2'd0};
        vecs[1] = '{2'b01, 3'b010, 32'h100, 32'h4, 0, 32'h2,
                    32'hDEAD_BEEF, 3, 6'b000001,
                    32'hDEAD_BEEF, 2'd1, 2'd0};
        vecs[2] = '{2'b10, 3'b000, 32'h203, 0, 0, 32'h55, 0,
                    3, 6'b001110, 32'hDEAD_BEEF, 2'd1, 2'd1};
        vecs[3] = '{2'b01, 3'b000, 32'h301, 32'h0, 0, 0, 32'h11,
                    3, 6'b000001, 32'h11, 2'd2, 2'd1};
        vecs[4] = '{2'b01, 3'b001, 32'h402, 32'h2, 0, 0, 32'h22,
                    3, 6'b000001, 32'h22, 2'd3, 2'd1};
        vecs[5] = '{2'b01, 3'b100, 32'h503, 32'h1, 0, 0, 32'h33,
                    3, 6'b000001, 32'h33, 2'd0, 2'd1};
        vecs[6] = '{2'b01, 3'b101, 32'h604, 32'h6, 0, 0, 32'h44,
                    3, 6'b000001, 32'h44, 2'd1, 2'd1};
        vecs[7] = '{2'b10, 3'b001, 32'h700, 0, 32'h2, 32'hAB, 0,
                    3, 6'b001110, 32'h44, 2'd1, 2'd2};
        vecs[8] = '{2'b10, 3'b010, 32'h800, 0, 32'h4, 32'hCD, 0,
                    3, 6'b001110, 32'h44, 2'd1, 2'd3};
        vecs[9] = '{2'b10, 3'b010, 32'h900, 0, 32'h8, 32'hEF, 0,
                    3, 6'b001110, 32'h44, 2'd1, 2'd0};

        @(negedge clk);
        @(negedge clk);
        chk("rst_mode_in_reset", memoryMode, M_NOP);
        reset = 1'b0;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_loaddata", loadData, 0);
        chk("rst_counts", {loadCount, storeCount}, 0);
        chk("rst_operands", rs1 | rs2 | immI | immS, 0);
        chk("rst_funct3", funct3, 0);

        for (int i = 0; i < 10; i++) begin
            txn(vecs[i].kind, vecs[i].f3, vecs[i].a, vecs[i].ii,
                vecs[i].is, vecs[i].b, vecs[i].mem, 1'b0,
                lat, md, ill1);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_modes", i), md, vecs[i].modes);
            chk($sformatf("v%0d_rs1", i), rs1, vecs[i].a);
            chk($sformatf("v%0d_rs2", i), rs2, vecs[i].b);
            chk($sformatf("v%0d_immI", i), immI, vecs[i].ii);
            chk($sformatf("v%0d_immS", i), immS, vecs[i].is);
            chk($sformatf("v%0d_f3", i), funct3, vecs[i].f3);
            chk($sformatf("v%0d_ready", i), ready, 0);
            @(negedge clk);
            chk($sformatf("v%0d_loaddata", i), loadData, vecs[i].ld);
            chk($sformatf("v%0d_lc", i), loadCount, vecs[i].lc);
            chk($sformatf("v%0d_sc", i), storeCount, vecs[i].sc);
            chk($sformatf("v%0d_flags", i), {fault, illegal}, 0);
            chk($sformatf("v%0d_ready_idle", i), ready, 1);
        end

        txn(2'b01, 3'b010, 32'h101, 0, 0, 0, 32'h9999_9999, 1'b1,
            lat, md, ill1);
        chk("uald_nodone", lat, -1);
        chk("uald_modes", md, 6'b000001);
        chk("uald_fault", fault, 1);
        chk("uald_loaddata_kept", loadData, 32'h44);
        chk("uald_lc", loadCount, 1);
        watch_halt("uald");

        do_reset();
        txn(2'b10, 3'b010, 32'h202, 0, 0, 32'h77, 0, 1'b1,
            lat, md, ill1);
        chk("uasw_nodone", lat, -1);
        chk("uasw_modes", md, 6'b000010);
        chk("uasw_fault", fault, 1);
        chk("uasw_illegal", illegal, 0);
        watch_halt("uasw");
        chk("uasw_sc", storeCount, 0);

        do_reset();
        txn(2'b10, 3'b100, 32'h10, 0, 0, 0, 0, 1'b0, lat, md, ill1);
        chk("ill_st_next_cycle", ill1, 1);
        chk("ill_st_modes", md, 6'b000000);
        chk("ill_st_nodone", lat, -1);
        chk("ill_st_fault", fault, 0);
        watch_halt("ill_st");
        do_reset();
        chk("ill_recover", {ready, illegal}, 2'b10);

        txn(2'b11, 3'b000, 32'h10, 0, 0, 0, 0, 1'b0, lat, md, ill1);
        chk("ill_k3_next_cycle", ill1, 1);
        chk("ill_k3_modes", md, 6'b000000);
        do_reset();
        txn(2'b01, 3'b011, 32'h10, 0, 0, 0, 0, 1'b0, lat, md, ill1);
        chk("ill_ld011", {ill1, md}, 7'b1000000);

        do_reset();
        txn(2'b10, 3'b010, 32'h300, 0, 0, 32'h1, 0, 1'b0,
            lat, md, ill1);
        @(negedge clk);
        chk("mid_pre_sc", storeCount, 1);
        start = 1'b1;
        accessKind = 2'b10;
        funct3In = 3'b010;
        rs1In = 32'h400;
        @(negedge clk);
        start = 1'b0;
        chk("mid_pre_mode", memoryMode, M_PRE);
        @(negedge clk);
        chk("mid_store_mode", memoryMode, M_STORE);
        reset = 1'b1;
        #1;
        chk("mid_reset_mode_nop", memoryMode, M_NOP);
        @(negedge clk);
        reset = 1'b0;
        chk("mid_ready", ready, 1);
        chk("mid_sc", storeCount, 0);
        chk("mid_fault", fault, 0);
        chk("mid_rs1", rs1, 0);

        do_reset();
        start = 1'b1;
        accessKind = 2'b01;
        funct3In = 3'b000;
        mem_val = 32'h5A5A_0001;
        dcount = 0;
        prev = -1;
        gap = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                dcount++;
                if (prev >= 0) gap += (c - prev == 4) ? 0 : 1;
                prev = c;
                if (dcount == 5) begin
                    start = 1'b0;
                    break;
                end
            end
        end
        chk("b2b_dones", dcount, 5);
        chk("b2b_gaps", gap, 0);
        @(negedge clk);
        chk("b2b_lc_wrap", loadCount, 1);
        chk("b2b_loaddata", loadData, 32'h5A5A_0001);
        chk("b2b_ready", ready, 1);
        txn(2'b00, 3'b111, 32'h1, 0, 0, 0, 0, 1'b0, lat, md, ill1);
        chk("none_latency", lat, 1);
        chk("none_flags", {fault, illegal}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
